// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
//   Bundles the fetch-side signals of the program counter sequencer.
//   master : the surrounding pipeline (PC adder, hazard unit, branch/jump
//            resolution, decode), which drives the requests and reads the PC.
//   slave  : the sequencer itself.
//
//   PCAddResult   m->s  32     PCResult+4 from the PC adder
//   Stall         m->s  1      hold PC
//   BranchTaken   m->s  1      redirect to BranchTarget
//   BranchTarget  m->s  32     branch target address
//   JumpEn        m->s  1      redirect to JumpTarget
//   JumpTarget    m->s  32     jump target address
//   Halt          m->s  1      stop fetching
//   PCResult      s->m  32     current PC
//   FetchValid    s->m  1      fetch at PCResult is valid
//   Flush         s->m  1      kill younger instructions this cycle
//   Fault         s->m  1      misaligned redirect trapped (sticky)
//   State         s->m  2      0 RUN, 1 BUBBLE, 2 HALTED, 3 FAULT
//   RedirectCount s->m  CNT_W  accepted redirects, saturating
// -----------------------------------------------------------------------------
interface pc_seq_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      PCAddResult;
  logic             Stall;
  logic             BranchTaken;
  logic [31:0]      BranchTarget;
  logic             JumpEn;
  logic [31:0]      JumpTarget;
  logic             Halt;
  logic [31:0]      PCResult;
  logic             FetchValid;
  logic             Flush;
  logic             Fault;
  logic [1:0]       State;
  logic [CNT_W-1:0] RedirectCount;

  modport master (
    output PCAddResult, Stall, BranchTaken, BranchTarget, JumpEn, JumpTarget, Halt,
    input  PCResult, FetchValid, Flush, Fault, State, RedirectCount
  );

  modport slave (
    input  PCAddResult, Stall, BranchTaken, BranchTarget, JumpEn, JumpTarget, Halt,
    output PCResult, FetchValid, Flush, Fault, State, RedirectCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Owns the program counter for the instruction fetch stage and picks the next
//   PC each cycle: sequential (PC adder), branch/jump redirect, stall or halt.
//   Inserts flush bubbles after accepted redirects, traps misaligned redirect
//   targets and counts accepted redirects.
//
//   Clk    in   clock, rising edge
//   Reset  in   asynchronous, active-low reset
//   bus    slave side of pc_seq_if (requests in, PC/status out)
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   RUN    | fetching; PC advances, holds on stall, accepts redirects
//   BUBBLE | post-redirect flush window; PC held, only redirects act
//   HALTED | halt decoded; everything ignored until reset
//   FAULT  | misaligned redirect trapped; PC frozen until reset
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic     Clk,
  input  logic     Reset,
  pc_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_BUBBLE = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_e;

  localparam logic [3:0]       BUB_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q;
  logic [31:0]      pc_q;
  logic [3:0]       bub_q;
  logic [CNT_W-1:0] rcnt_q;

  logic        redirect_req;
  logic        redirect_open;
  logic        target_misaligned;
  logic        redirect_take;
  logic        redirect_trap;
  logic [31:0] target;

  // Branch outranks jump when both resolve in the same cycle.
  assign redirect_req      = bus.BranchTaken | bus.JumpEn;
  assign target            = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
  assign target_misaligned = |target[1:0];
  assign redirect_open     = (state_q == S_RUN) || (state_q == S_BUBBLE);
  assign redirect_take     = redirect_open & redirect_req & ~target_misaligned;
  assign redirect_trap     = redirect_open & redirect_req & target_misaligned;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      bub_q   <= 4'd0;
      rcnt_q  <= '0;
    end else begin
      unique case (state_q)
        S_RUN, S_BUBBLE: begin
          if (redirect_trap) begin
            // PC stays at the last good value so the trap handler sees it.
            state_q <= S_FAULT;
          end else if (redirect_take) begin
            pc_q <= target;
            if (rcnt_q != CNT_MAX) rcnt_q <= rcnt_q + CNT_W'(1);
            if (FLUSH_CYCLES == 0) begin
              state_q <= S_RUN;
            end else begin
              bub_q   <= BUB_LOAD;
              state_q <= S_BUBBLE;
            end
          end else if (state_q == S_RUN) begin
            if (bus.Halt)        state_q <= S_HALTED;
            else if (!bus.Stall) pc_q    <= bus.PCAddResult;
          end else begin
            // Bubble drains regardless of stall/halt; last count returns to RUN.
            if (bub_q <= 4'd1) begin
              bub_q   <= 4'd0;
              state_q <= S_RUN;
            end else begin
              bub_q <= bub_q - 4'd1;
            end
          end
        end
        S_HALTED, S_FAULT: ;
        default: state_q <= S_FAULT;
      endcase
    end
  end

  assign bus.PCResult      = pc_q;
  assign bus.State         = state_q;
  assign bus.FetchValid    = (state_q == S_RUN);
  assign bus.Fault         = (state_q == S_FAULT);
  // Gated by Reset so a redirect seen during reset never flushes.
  assign bus.Flush         = Reset & redirect_take;
  assign bus.RedirectCount = rcnt_q;

endmodule
